// File: rtl/fft_pair_bridge.sv
// rtl/fft_pair_bridge.sv - RAM read-port to butterfly bridge: aligns slot control with read latency and pairs operands.
module fft_pair_bridge #(
  parameter int FFT_N  = 10,
  parameter int FFT_DW = 16,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                iact,
  input  logic [1:0]          ictrl,
  input  logic [FFT_N-2:0]    iaddr,
  input  logic [2*FFT_DW-1:0] idata_a,
  input  logic [2*FFT_DW-1:0] idata_b,
  output logic                oact,
  output logic [1:0]          octrl,
  output logic [FFT_N-2:0]    oaddr,
  output logic [2*FFT_DW-1:0] oa,
  output logic [2*FFT_DW-1:0] ob,
  output logic                o_err
);

  localparam int AW = FFT_N - 1;
  localparam int DW = 2 * FFT_DW;
  localparam int CW = 3 + AW;

  localparam logic [1:0] MODE_EVEN = 2'b00;
  localparam logic [1:0] MODE_RSVD = 2'b01;
  localparam logic [1:0] MODE_ODD  = 2'b11;

  // Stage RD_LAT is the pipe head: it describes the slot whose words sit in e1/o1.
  logic [CW-1:0] cpipe [0:RD_LAT];
  logic [DW-1:0] e1, o1, o2;
  logic          pend_even;

  logic          head_act;
  logic [1:0]    head_ctrl;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] sel_a, sel_b;
  logic          seq_err;

  assign head_act  = cpipe[RD_LAT][CW-1];
  assign head_ctrl = cpipe[RD_LAT][CW-2:CW-3];
  assign head_addr = cpipe[RD_LAT][AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) cpipe[i] <= '0;
    end else if (en) begin
      cpipe[0] <= {iact, ictrl, iaddr};
      for (int i = 1; i <= RD_LAT; i++) cpipe[i] <= cpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      e1 <= idata_a;
      o1 <= idata_b;
      o2 <= o1;
    end
  end

  // Even pairs take the next slot's even word straight off the read port.
  always_comb begin
    sel_a = e1;
    sel_b = o1;
    case (head_ctrl)
      MODE_EVEN: begin
        sel_a = e1;
        sel_b = idata_a;
      end
      MODE_ODD: begin
        sel_a = o2;
        sel_b = o1;
      end
      default: begin
        sel_a = e1;
        sel_b = o1;
      end
    endcase
  end

  always_comb begin
    seq_err = 1'b0;
    if (head_act && head_ctrl == MODE_RSVD) seq_err = 1'b1;
    if (head_act && head_ctrl == MODE_ODD && !pend_even) seq_err = 1'b1;
    if (pend_even && !(head_act && head_ctrl == MODE_ODD)) seq_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oact      <= 1'b0;
      octrl     <= 2'b00;
      oaddr     <= '0;
      oa        <= '0;
      ob        <= '0;
      o_err     <= 1'b0;
      pend_even <= 1'b0;
    end else if (en) begin
      oact      <= head_act;
      octrl     <= head_ctrl;
      oaddr     <= head_addr;
      oa        <= sel_a;
      ob        <= sel_b;
      o_err     <= o_err | seq_err;
      pend_even <= head_act && (head_ctrl == MODE_EVEN);
    end
  end

endmodule

// File: tb/tb_fft_pair_bridge.sv
// tb/tb_fft_pair_bridge.sv - scoreboard bench for fft_pair_bridge at RD_LAT 2, 1 and 8 in parallel.
module tb_fft_pair_bridge;

  typedef struct packed {
    logic        act;
    logic [1:0]  ctrl;
    logic [8:0]  addr;
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, en, iact;
  logic [1:0]  ictrl;
  logic [8:0]  iaddr;
  logic [31:0] da [3];
  logic [31:0] db [3];
  logic        oact_w [3];
  logic [1:0]  octrl_w [3];
  logic [8:0]  oaddr_w [3];
  logic [31:0] oa_w [3];
  logic [31:0] ob_w [3];
  logic        oerr_w [3];

  int   errors = 0;
  int   checks = 0;
  int   g = 0;
  bit   pending = 0;
  bit   err_m = 0;
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];
  exp_t last [3];

  always #5 clk = ~clk;

  fft_pair_bridge #(.FFT_N(10), .FFT_DW(16), .RD_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .en(en), .iact(iact), .ictrl(ictrl), .iaddr(iaddr),
    .idata_a(da[0]), .idata_b(db[0]), .oact(oact_w[0]), .octrl(octrl_w[0]),
    .oaddr(oaddr_w[0]), .oa(oa_w[0]), .ob(ob_w[0]), .o_err(oerr_w[0]));
  fft_pair_bridge #(.FFT_N(10), .FFT_DW(16), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .iact(iact), .ictrl(ictrl), .iaddr(iaddr),
    .idata_a(da[1]), .idata_b(db[1]), .oact(oact_w[1]), .octrl(octrl_w[1]),
    .oaddr(oaddr_w[1]), .oa(oa_w[1]), .ob(ob_w[1]), .o_err(oerr_w[1]));
  fft_pair_bridge #(.FFT_N(10), .FFT_DW(16), .RD_LAT(8)) dut2 (
    .clk(clk), .reset(reset), .en(en), .iact(iact), .ictrl(ictrl), .iaddr(iaddr),
    .idata_a(da[2]), .idata_b(db[2]), .oact(oact_w[2]), .octrl(octrl_w[2]),
    .oaddr(oaddr_w[2]), .oa(oa_w[2]), .ob(ob_w[2]), .o_err(oerr_w[2]));

  function automatic int rd_lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 8;
  endfunction

  function automatic logic [31:0] e_of(input int n);
    logic [15:0] k;
    k = n[15:0];
    return {16'h1000 + k, 16'h0100 + k};
  endfunction

  function automatic logic [31:0] o_of(input int n);
    logic [15:0] k;
    k = n[15:0];
    return {16'h2000 + k, 16'h0200 + k};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s slot=%0d got=%h want=%h", tag, g, got, want);
    end
  endtask

  task automatic cmp(input int i, input exp_t ex, input bit data_chk);
    check($sformatf("lat%0d oact", rd_lat_of(i)), 64'(oact_w[i]), 64'(ex.act));
    check($sformatf("lat%0d octrl", rd_lat_of(i)), 64'(octrl_w[i]), 64'(ex.ctrl));
    check($sformatf("lat%0d oaddr", rd_lat_of(i)), 64'(oaddr_w[i]), 64'(ex.addr));
    check($sformatf("lat%0d o_err", rd_lat_of(i)), 64'(oerr_w[i]), 64'(ex.err));
    if (data_chk) begin
      check($sformatf("lat%0d oa", rd_lat_of(i)), 64'(oa_w[i]), 64'(ex.a));
      check($sformatf("lat%0d ob", rd_lat_of(i)), 64'(ob_w[i]), 64'(ex.b));
    end
  endtask

  task automatic step(input bit rst, input bit e, input bit act, input logic [1:0] ctrl,
                      input logic [8:0] addr);
    exp_t ex, p0, p1, p2, dummy;
    bit   viol;
    reset = rst;
    en    = e;
    iact  = act;
    ictrl = ctrl;
    iaddr = addr;
    for (int i = 0; i < 3; i++) begin
      if (e) begin
        da[i] = e_of(g - rd_lat_of(i));
        db[i] = o_of(g - rd_lat_of(i));
      end else begin
        da[i] = $urandom;
        db[i] = $urandom;
      end
    end
    dummy = '0;
    ex = '0;
    p0 = '0;
    p1 = '0;
    p2 = '0;
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
      for (int k = 0; k < 3; k++) q0.push_back(dummy);
      for (int k = 0; k < 2; k++) q1.push_back(dummy);
      for (int k = 0; k < 9; k++) q2.push_back(dummy);
      pending = 0;
      err_m = 0;
    end else if (e) begin
      ex.act  = act;
      ex.ctrl = ctrl;
      ex.addr = addr;
      case (ctrl)
        2'b00: begin ex.a = e_of(g);     ex.b = e_of(g + 1); end
        2'b11: begin ex.a = o_of(g - 1); ex.b = o_of(g);     end
        default: begin ex.a = e_of(g);   ex.b = o_of(g);     end
      endcase
      viol = (act && ctrl == 2'b01) || (act && ctrl == 2'b11 && !pending) ||
             (pending && !(act && ctrl == 2'b11));
      err_m   = err_m | viol;
      pending = act && (ctrl == 2'b00);
      ex.err  = err_m;
      q0.push_back(ex);
      q1.push_back(ex);
      q2.push_back(ex);
      p0 = q0.pop_front();
      p1 = q1.pop_front();
      p2 = q2.pop_front();
    end
    if (e) g++;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) cmp(i, dummy, 1'b1);
    end else if (e) begin
      cmp(0, p0, p0.act);
      cmp(1, p1, p1.act);
      cmp(2, p2, p2.act);
    end else begin
      for (int i = 0; i < 3; i++) cmp(i, last[i], 1'b1);
    end
    for (int i = 0; i < 3; i++)
      last[i] = {oact_w[i], octrl_w[i], oaddr_w[i], oa_w[i], ob_w[i], oerr_w[i]};
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 2'($urandom_range(0, 3)), 9'($urandom));
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1, 1, 1'($urandom), 2'($urandom), 9'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    iact  = 1'b0;
    ictrl = 2'b00;
    iaddr = '0;
    for (int i = 0; i < 3; i++) begin
      da[i] = '0;
      db[i] = '0;
      last[i] = '0;
    end
    @(negedge clk);
    do_reset(5);

    for (int s = 0; s < 8; s++) step(0, 1, 1, 2'b10, 9'(s * 3 + 5));
    idle(11);

    for (int s = 0; s < 8; s++) step(0, 1, 1, (s % 2 == 1) ? 2'b11 : 2'b00, 9'(s + 64));
    idle(11);

    step(0, 1, 1, 2'b00, 9'd100);
    for (int k = 0; k < 3; k++) step(0, 0, 1'($urandom), 2'($urandom), 9'($urandom));
    step(0, 1, 1, 2'b11, 9'd101);
    step(0, 1, 1, 2'b00, 9'd102);
    step(0, 1, 1, 2'b11, 9'd103);
    idle(11);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 2'b00, 9'd0);
    idle(3);

    step(0, 1, 1, 2'b11, 9'd200);
    idle(14);
    do_reset(2);
    step(0, 1, 1, 2'b01, 9'd300);
    idle(14);
    do_reset(2);
    idle(11);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        step(1, 1, 0, 2'b00, 9'd0);
      end else if ($urandom_range(0, 3) == 0) begin
        step(0, 0, 1'($urandom), 2'($urandom), 9'($urandom));
      end else if ($urandom_range(0, 9) == 0) begin
        step(0, 1, 1'($urandom), 2'($urandom), 9'($urandom));
      end else begin
        step(0, 1, 1, 2'b00, 9'($urandom));
        while ($urandom_range(0, 2) == 0) step(0, 0, 1'($urandom), 2'($urandom), 9'($urandom));
        step(0, 1, 1, 2'b11, 9'($urandom));
      end
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_pair_bridge.md
# fft_pair_bridge

Registered operand-pairing bridge between the FFT working RAM read port and the radix-2 butterfly input. It aligns control, activity and write-back address with a RAM read latency set by a parameter. It then forms butterfly operand pairs from consecutive read words: pass-through for stage 1, and even/even or odd/odd pairing for later stages. A global clock enable stalls the whole pipeline, and a sticky flag reports illegal control sequences.

## Interface
- FFT_N, 10: log2 of transform length; address width is FFT_N-1.
- FFT_DW, 16: real/imag component width; data words are 2*FFT_DW bits.
- RD_LAT, 2: cycles from issuing iaddr/ictrl/iact to idata_a/idata_b valid; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  pipeline enable; 0 freezes every register, including o_err.
- iact  in  1  slot active, issued with iaddr.
- ictrl  in  2  pairing mode: 10 = stage 1; 00 = stage 2..n even slot; 11 = stage 2..n odd slot; 01 = reserved.
- iaddr  in  FFT_N-1  write-back address for the slot.
- idata_a  in  2*FFT_DW  even-bank word E(s), valid RD_LAT enabled cycles after issue.
- idata_b  in  2*FFT_DW  odd-bank word O(s), valid with idata_a.
- oact  out  1  output slot active.
- octrl  out  2  ictrl delayed.
- oaddr  out  FFT_N-1  iaddr delayed.
- oa  out  2*FFT_DW  butterfly operand A.
- ob  out  2*FFT_DW  butterfly operand B.
- o_err  out  1  sticky sequence error.

## Operation
- Control pipe: a (RD_LAT+2)-deep shift register for {iact, ictrl, iaddr}. It advances only when en=1.
- Data pipe: registers E1, O1 and O2, advancing only when en=1.
  - E1 and O1 capture idata_a and idata_b.
  - O2 captures O1.
- Output registers load on every enabled edge. They select on the ctrl word at the head of the control pipe, which belongs to slot s, the slot now held in E1/O1:
  - 10: oa<=E1=E(s), ob<=O1=O(s).
  - 00: oa<=E1=E(s), ob<=idata_a=E(s+1).
  - 11: oa<=O2=O(s-1), ob<=O1=O(s).
  - 01: treated as 10, and o_err is set if the slot is active.
- Sequence check, active slots only, evaluated at the pipe head:
  - An active 11 slot must have an active 00 slot on the immediately preceding enabled cycle. Otherwise o_err<=1.
  - An active 00 slot must be followed by an active 11 slot on the next enabled cycle. Otherwise o_err<=1.
- Inactive slots (iact=0) still shift data. oact=0 for them, and oa/ob contents are don't-care.
- o_err is cleared only by reset.
- Arithmetic: none. This is pure data movement, so no width changes.

## Timing
- Reset values: oact=0, octrl=00, oaddr=0, oa=0, ob=0, o_err=0. All control pipe stages clear to iact=0 and ctrl=00.
- Data registers E1/O1/O2 are not reset.
- Latency: a slot issued at enabled cycle t appears on all outputs at enabled cycle t+RD_LAT+2. This holds for every mode, and all outputs are registered.
- The 00 mode reads idata_a combinationally into the output register. Correctness requires that slot s+1 data is presented on the enabled cycle directly after slot s.
- Stall: with en=0, every output and internal register holds its value. Resuming with en=1 continues the stream as if no stall occurred. Stalls between a 00 slot and its 11 partner are legal.
- Reset mid-stream: the next cycle shows reset values. The first active output appears RD_LAT+2 enabled cycles after the first post-reset issue. The pairing check restarts with no pending 00.
- Back-to-back 00/11 pairs at full rate produce one pair per cycle with no bubbles.

## Test plan
- Reset: hold reset with random inputs -> all outputs 0. After release, first issue at t=0 with RD_LAT=2 -> oact=1 at t=4.
- Stage 1: 8 slots of ctrl=10 with E(s)=0x100+s and O(s)=0x200+s -> oa=0x100+s, ob=0x200+s, oaddr=iaddr(s), latency RD_LAT+2.
- Stage n: alternating 00/11 over slots 0..7 -> slot0 oa=E0, ob=E1; slot1 oa=O0, ob=O1; slot2 oa=E2, ob=E3, and so on. o_err stays 0.
- Stall: drop en for 3 cycles between a 00 slot and its 11 slot -> outputs frozen during the stall, pairing identical to the no-stall run, o_err=0.
- Errors: an active 11 with no preceding 00 -> o_err=1 and it stays 1. An active 01 in a fresh run -> o_err=1 and pass-through data. Reset -> o_err=0.
- Sweep RD_LAT=1 and RD_LAT=8 on the stage-n run -> same data sequence, latency 3 and 10 respectively.
